// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
//   parity_e   : frame parity mode (none / odd / even)
//   rx_state_e : receiver frame FSM states
//   uart_div   : clocks per oversample tick, clk / (baud * os)
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    function automatic int unsigned uart_div(input int unsigned clk,
                                             input int unsigned baud,
                                             input int unsigned os);
        return clk / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Received-word handshake between the UART receiver and its consumer.
//   rx_data    : received word, LSB = first bit on the line
//   rx_valid   : rx_data and error flags are valid
//   rx_ready   : consumer accepts the word when rx_valid && rx_ready
//   parity_err : parity mismatch in the held word
//   frame_err  : a stop bit of the held word sampled low
//   overrun    : sticky, a frame was dropped since the last accept
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
//   clk_fpga : system clock
//   reset    : synchronous, active-high
//   tick_c   : high while the counter sits at DIV-1
module uart_baud_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic clk_fpga,
    input  logic reset,
    output logic tick_c
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick_c = (cnt == CW'(DIV - 1));

    // Count 0..DIV-1 and wrap on the tick
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled, 2-of-3 voted bits, configurable
// data width / parity / stop bits, one-entry holding register with handshake.
//   clk_fpga : system clock
//   reset    : synchronous, active-high
//   RxD      : asynchronous serial line, idles high
//   busy     : high whenever the frame FSM is not idle
//   rx_if    : received word, error flags and valid/ready handshake
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic            clk_fpga,
    input  logic            reset,
    input  logic            RxD,
    output logic            busy,
    uart_rx_param_if.master rx_if
);
    localparam int unsigned DIV        = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned MID        = OVERSAMPLE / 2;
    localparam int unsigned SW         = $clog2(OVERSAMPLE);
    localparam int unsigned BW         = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam parity_e     PAR_MODE   = parity_e'(2'(PARITY));
    localparam logic        PAR_TARGET = (PAR_MODE == PAR_ODD);

    rx_state_e            state, state_next;
    logic                 rx_meta, rxs;
    logic                 tick_c;
    logic [SW-1:0]        scnt;
    logic [BW-1:0]        bitcnt;
    logic                 samp_a, samp_b;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_pend, ferr_pend;
    logic                 stop_idx;
    logic                 vote_c, vote_tick_c, wrap_c, last_stop_c, commit_c;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk_fpga (clk_fpga),
        .reset    (reset),
        .tick_c   (tick_c)
    );

    assign vote_c      = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
    assign vote_tick_c = tick_c && (scnt == SW'(MID + 1));
    assign wrap_c      = tick_c && (scnt == SW'(OVERSAMPLE - 1));
    assign last_stop_c = (STOP_BITS == 1) ? 1'b1 : stop_idx;

    // Two-flop synchroniser, idles high
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rxs     <= rx_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; commit fires at the vote of the last stop bit
    always_comb begin
        state_next = state;
        commit_c   = 1'b0;
        case (state)
            RX_IDLE: begin
                if (tick_c && !rxs) state_next = RX_START;
            end
            RX_START: begin
                if (vote_tick_c && vote_c) state_next = RX_IDLE;
                else if (wrap_c)           state_next = RX_DATA;
            end
            RX_DATA: begin
                if (wrap_c && bitcnt == BW'(DATA_BITS - 1))
                    state_next = (PAR_MODE != PAR_NONE) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (wrap_c) state_next = RX_STOP;
            end
            RX_STOP: begin
                if (vote_tick_c && last_stop_c) begin
                    commit_c   = 1'b1;
                    state_next = vote_c ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (rxs) state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // Bit timing, voting samples, shift register and pending error flags
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            scnt      <= '0;
            bitcnt    <= '0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            shreg     <= '0;
            par_pend  <= 1'b0;
            ferr_pend <= 1'b0;
            stop_idx  <= 1'b0;
        end else begin
            if (tick_c && scnt == SW'(MID - 1)) samp_a <= rxs;
            if (tick_c && scnt == SW'(MID))     samp_b <= rxs;

            // scnt is held at 0 while idle so a start tick begins a fresh bit
            if (state == RX_IDLE || state == RX_BREAK) scnt <= '0;
            else if (wrap_c)                           scnt <= '0;
            else if (tick_c)                           scnt <= scnt + SW'(1);

            if (state != RX_DATA) bitcnt <= '0;
            else if (wrap_c)      bitcnt <= bitcnt + BW'(1);

            if (state == RX_DATA && vote_tick_c)
                shreg <= {vote_c, shreg[DATA_BITS-1:1]};

            if (state == RX_IDLE) par_pend <= 1'b0;
            else if (state == RX_PARITY && vote_tick_c)
                par_pend <= ((^shreg) ^ vote_c) != PAR_TARGET;

            if (state == RX_IDLE) ferr_pend <= 1'b0;
            else if (state == RX_STOP && vote_tick_c && !vote_c) ferr_pend <= 1'b1;

            if (state != RX_STOP) stop_idx <= 1'b0;
            else if (wrap_c)      stop_idx <= 1'b1;
        end
    end

    // Holding register, handshake and sticky overrun
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            rx_if.rx_data    <= '0;
            rx_if.rx_valid   <= 1'b0;
            rx_if.parity_err <= 1'b0;
            rx_if.frame_err  <= 1'b0;
            rx_if.overrun    <= 1'b0;
            busy             <= 1'b0;
        end else begin
            busy <= (state_next != RX_IDLE);
            if (rx_if.rx_valid && rx_if.rx_ready) rx_if.overrun <= 1'b0;
            if (commit_c) begin
                if (!rx_if.rx_valid || rx_if.rx_ready) begin
                    rx_if.rx_data    <= shreg;
                    rx_if.parity_err <= par_pend;
                    rx_if.frame_err  <= ferr_pend | ~vote_c;
                    rx_if.rx_valid   <= 1'b1;
                end else begin
                    rx_if.overrun <= 1'b1;
                end
            end else if (rx_if.rx_valid && rx_if.rx_ready) begin
                rx_if.rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance (OVERSAMPLE=16, DIV=2) and a
// 7-bit even-parity, 2-stop instance (OVERSAMPLE=8, DIV=4), both 32 clocks/bit.
module tb_uart_rx_param;
    localparam int unsigned CLK_FREQ = 3_200_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int          BIT_CLKS = 32;

    logic clk_fpga = 1'b0;
    always #5 clk_fpga = ~clk_fpga;

    logic reset;
    logic rxd_a, rxd_b;
    logic busy_a, busy_b;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_cnt_a = 0;

    uart_rx_param_if #(.DATA_BITS(8)) if_a ();
    uart_rx_param_if #(.DATA_BITS(7)) if_b ();

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk_fpga (clk_fpga), .reset (reset), .RxD (rxd_a), .busy (busy_a), .rx_if (if_a)
    );

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(8),
                    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk_fpga (clk_fpga), .reset (reset), .RxD (rxd_b), .busy (busy_b), .rx_if (if_b)
    );

    // Accepted words as {parity_err, frame_err, data[8:0]}
    logic [10:0] got_a[$];
    logic [10:0] got_b[$];

    always @(negedge clk_fpga) begin
        if (if_a.rx_valid && if_a.rx_ready)
            got_a.push_back({if_a.parity_err, if_a.frame_err, 1'b0, if_a.rx_data});
        if (if_b.rx_valid && if_b.rx_ready)
            got_b.push_back({if_b.parity_err, if_b.frame_err, 2'b00, if_b.rx_data});
        if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int idx, input logic v, input int n);
        if (idx == 0) rxd_a = v;
        else          rxd_b = v;
        repeat (n) @(posedge clk_fpga);
        #1;
    endtask

    // One serial frame; bad_par inverts the correct parity bit
    task automatic send_frame(input int idx, input logic [8:0] data, input int nd,
                              input int par_mode, input logic bad_par,
                              input logic stop0, input logic stop1, input int nstop);
        int   ones;
        logic pbit;
        ones = 0;
        drive(idx, 1'b0, BIT_CLKS);
        for (int i = 0; i < nd; i++) begin
            drive(idx, data[i], BIT_CLKS);
            ones += int'(data[i]);
        end
        if (par_mode != 0) begin
            pbit = (par_mode == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
            drive(idx, pbit ^ bad_par, BIT_CLKS);
        end
        drive(idx, stop0, BIT_CLKS);
        if (nstop == 2) drive(idx, stop1, BIT_CLKS);
    endtask

    task automatic pop_check(input int idx, input string tag, input logic [10:0] exp);
        logic [10:0] w;
        w = '1;
        if (idx == 0) begin
            check({tag, "_present"}, 32'(got_a.size() > 0), 32'd1);
            if (got_a.size() > 0) w = got_a.pop_front();
        end else begin
            check({tag, "_present"}, 32'(got_b.size() > 0), 32'd1);
            if (got_b.size() > 0) w = got_b.pop_front();
        end
        check(tag, 32'(w), 32'(exp));
    endtask

    initial begin
        logic [10:0] exp_q[$];
        logic [8:0]  d;
        logic        bad, s0;
        int          c0;

        reset = 1'b1;
        rxd_a = 1'b1;
        rxd_b = 1'b1;
        if_a.rx_ready = 1'b1;
        if_b.rx_ready = 1'b1;
        repeat (3) @(posedge clk_fpga);
        #1;
        check("rst_a_outs", 32'({if_a.rx_valid, if_a.parity_err, if_a.frame_err,
                                 if_a.overrun, busy_a, if_a.rx_data}), 32'd0);
        check("rst_b_outs", 32'({if_b.rx_valid, if_b.parity_err, if_b.frame_err,
                                 if_b.overrun, busy_b, if_b.rx_data}), 32'd0);
        reset = 1'b0;
        drive(0, 1'b1, BIT_CLKS);

        // 8N1 0xA5
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1);
        drive(0, 1'b1, BIT_CLKS);
        check("a5_count", 32'(got_a.size()), 32'd1);
        pop_check(0, "a5_word", {1'b0, 1'b0, 9'h0A5});
        check("a5_idle", 32'({if_a.rx_valid, if_a.overrun, busy_a}), 32'd0);

        // 7E2 0x55, wrong then correct parity bit
        send_frame(1, 9'h055, 7, 2, 1'b1, 1'b1, 1'b1, 2);
        send_frame(1, 9'h055, 7, 2, 1'b0, 1'b1, 1'b1, 2);
        drive(1, 1'b1, BIT_CLKS);
        pop_check(1, "par_bad", {1'b1, 1'b0, 9'h055});
        pop_check(1, "par_good", {1'b0, 1'b0, 9'h055});

        // Short low glitch: false start
        c0 = busy_cnt_a;
        drive(0, 1'b0, 6);
        drive(0, 1'b1, 2 * BIT_CLKS);
        check("glitch_busy_pulsed", 32'(busy_cnt_a != c0), 32'd1);
        check("glitch_no_word", 32'(got_a.size()), 32'd0);
        check("glitch_idle", 32'({if_a.rx_valid, busy_a}), 32'd0);

        // Low stop bit, line held low, then a good frame
        send_frame(0, 9'h000, 8, 0, 1'b0, 1'b0, 1'b1, 1);
        drive(0, 1'b0, 3 * BIT_CLKS);
        check("break_one_word", 32'(got_a.size()), 32'd1);
        check("break_busy", 32'(busy_a), 32'd1);
        drive(0, 1'b1, BIT_CLKS);
        check("break_released", 32'(busy_a), 32'd0);
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1'b1, 1'b1, 1);
        drive(0, 1'b1, BIT_CLKS);
        pop_check(0, "break_ferr_word", {1'b0, 1'b1, 9'h000});
        pop_check(0, "after_break_word", {1'b0, 1'b0, 9'h03C});

        // Overrun with consumer stalled
        if_a.rx_ready = 1'b0;
        send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1, 1'b1, 1);
        send_frame(0, 9'h022, 8, 0, 1'b0, 1'b1, 1'b1, 1);
        send_frame(0, 9'h033, 8, 0, 1'b0, 1'b1, 1'b1, 1);
        drive(0, 1'b1, 8);
        check("ovr_held", 32'({if_a.rx_valid, if_a.overrun, if_a.frame_err, if_a.rx_data}),
              32'({1'b1, 1'b1, 1'b0, 8'h11}));
        if_a.rx_ready = 1'b1;
        @(posedge clk_fpga);
        #1;
        if_a.rx_ready = 1'b0;
        check("ovr_after_accept", 32'({if_a.rx_valid, if_a.overrun}), 32'd0);
        pop_check(0, "ovr_accepted", {1'b0, 1'b0, 9'h011});
        check("ovr_single", 32'(got_a.size()), 32'd0);

        // Reset in the middle of DATA with a word held
        send_frame(0, 9'h042, 8, 0, 1'b0, 1'b1, 1'b1, 1);
        drive(0, 1'b1, 8);
        check("pre_rst_held", 32'(if_a.rx_valid), 32'd1);
        drive(0, 1'b0, BIT_CLKS);
        drive(0, 1'b1, BIT_CLKS);
        drive(0, 1'b0, BIT_CLKS / 2);
        check("pre_rst_busy", 32'(busy_a), 32'd1);
        reset = 1'b1;
        rxd_a = 1'b1;
        repeat (2) @(posedge clk_fpga);
        #1;
        check("mid_rst_outs", 32'({if_a.rx_valid, if_a.parity_err, if_a.frame_err,
                                   if_a.overrun, busy_a, if_a.rx_data}), 32'd0);
        reset = 1'b0;
        if_a.rx_ready = 1'b1;
        drive(0, 1'b1, BIT_CLKS);
        send_frame(0, 9'h07E, 8, 0, 1'b0, 1'b1, 1'b1, 1);
        drive(0, 1'b1, BIT_CLKS);
        pop_check(0, "post_rst_word", {1'b0, 1'b0, 9'h07E});
        check("post_rst_single", 32'(got_a.size()), 32'd0);

        // Random 8N1 frames with random idle gaps (including none)
        for (int k = 0; k < 8; k++) begin
            d = 9'($urandom_range(0, 255));
            exp_q.push_back({1'b0, 1'b0, d});
            send_frame(0, d, 8, 0, 1'b0, 1'b1, 1'b1, 1);
            drive(0, 1'b1, int'($urandom_range(0, 40)));
        end
        drive(0, 1'b1, BIT_CLKS);
        check("rand_a_count", 32'(got_a.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0) pop_check(0, "rand_a_word", exp_q.pop_front());

        // Random 7E2 frames: random parity fault, random low first stop bit
        for (int k = 0; k < 8; k++) begin
            d   = 9'($urandom_range(0, 127));
            bad = 1'($urandom_range(0, 1));
            s0  = 1'($urandom_range(0, 1));
            exp_q.push_back({bad, ~s0, d});
            send_frame(1, d, 7, 2, bad, s0, 1'b1, 2);
            drive(1, 1'b1, int'($urandom_range(0, 40)));
        end
        drive(1, 1'b1, BIT_CLKS);
        check("rand_b_count", 32'(got_b.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0) pop_check(1, "rand_b_word", exp_q.pop_front());

        check("final_a_empty", 32'(got_a.size()), 32'd0);
        check("final_b_empty", 32'(got_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
